// File: rtl/npu_stream_pkg.sv
// Shared definitions for the NPU window streamer: FSM states, border modes,
// the 3x3 tap offset table and a constant clog2 helper.
package npu_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic BORDER_SKIP = 1'b0;
    localparam logic BORDER_PAD  = 1'b1;

    localparam int NUM_TAPS = 9;

    // Tap offsets biased by +1 (0 means -1, 1 means 0, 2 means +1) so that all
    // coordinate arithmetic stays unsigned. Column-major tap order.
    localparam logic [1:0] TAP_DR1 [NUM_TAPS] = '{2'd0, 2'd1, 2'd2,
                                                  2'd0, 2'd1, 2'd2,
                                                  2'd0, 2'd1, 2'd2};
    localparam logic [1:0] TAP_DC1 [NUM_TAPS] = '{2'd0, 2'd0, 2'd0,
                                                  2'd1, 2'd1, 2'd1,
                                                  2'd2, 2'd2, 2'd2};

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tap_skid_fifo.sv
// Small circular skid buffer that absorbs in-flight ROM returns while the
// downstream FIFO is full. Reports occupancy so the issuer can throttle.
module tap_skid_fifo
    import npu_stream_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer wrap and occupancy update; overflow/underflow requests are dropped.
    always_comb begin
        push_ok  = push && (count_q < CNT_W'(DEPTH));
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and count registers; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/npu_window_streamer.sv
// Walks a packed-pixel ROM and streams the 3x3 neighbourhood of every centre
// pixel into the NPU input FIFO, with lossless back-pressure via a skid buffer.
module npu_window_streamer
    import npu_stream_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int PIX_W   = 8,
    parameter int WORD_W  = 64,
    parameter int OUT_W   = 32,
    parameter int ROM_LAT = 1,
    localparam int ADDR_W = (clog2(IMG_W * IMG_H * PIX_W / WORD_W) < 1) ? 1
                            : clog2(IMG_W * IMG_H * PIX_W / WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              border_mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    input  logic              fifo_full,
    output logic [OUT_W-1:0]  fifo_data,
    output logic              fifo_we
);

    localparam int LANES  = WORD_W / PIX_W;
    localparam int PA_W   = clog2(IMG_W * IMG_H);
    localparam int LANE_W = (clog2(LANES) < 1) ? 1 : clog2(LANES);
    localparam int ROW_W  = clog2(IMG_H + 2);
    localparam int COL_W  = clog2(IMG_W + 2);
    localparam int TAP_W  = clog2(NUM_TAPS);
    localparam int DEPTH  = ROM_LAT + 2;
    localparam int CNT_W  = clog2(DEPTH + 1);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;

    logic               pipe_valid_q [ROM_LAT];
    logic               pipe_valid_d [ROM_LAT];
    logic [LANE_W-1:0]  pipe_lane_q  [ROM_LAT];
    logic [LANE_W-1:0]  pipe_lane_d  [ROM_LAT];
    logic               pipe_pad_q   [ROM_LAT];
    logic               pipe_pad_d   [ROM_LAT];

    logic [ROW_W-1:0]   row_b, row_first, row_last;
    logic [COL_W-1:0]   col_b, col_first, col_last;
    logic [PA_W-1:0]    pix_addr;
    int                 pix_int;
    logic               tap_pad;
    logic [ADDR_W-1:0]  word_addr;
    logic [LANE_W-1:0]  lane_cur;
    logic [CNT_W-1:0]   inflight;
    logic               issue;
    logic               drain_empty;

    logic [PIX_W-1:0]   lane_pix [LANES];
    logic               push_valid;
    logic [PIX_W-1:0]   push_pix;
    logic [PIX_W-1:0]   skid_head;
    logic [CNT_W-1:0]   skid_count;
    logic               skid_empty;

    // Split the ROM word into pixel lanes, lane 0 in the LSBs.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_pix[gi] = rom_data[gi*PIX_W +: PIX_W];
    end

    // Tap geometry: biased coordinates keep bounds checks free of signed wrap.
    always_comb begin
        row_first = (mode_q == BORDER_PAD) ? '0 : ROW_W'(1);
        row_last  = (mode_q == BORDER_PAD) ? ROW_W'(IMG_H - 1) : ROW_W'(IMG_H - 2);
        col_first = (mode_q == BORDER_PAD) ? '0 : COL_W'(1);
        col_last  = (mode_q == BORDER_PAD) ? COL_W'(IMG_W - 1) : COL_W'(IMG_W - 2);
        row_b     = row_q + ROW_W'(TAP_DR1[tap_q]);
        col_b     = col_q + COL_W'(TAP_DC1[tap_q]);
        tap_pad   = (row_b == '0) || (row_b > ROW_W'(IMG_H))
                 || (col_b == '0) || (col_b > COL_W'(IMG_W));
        pix_addr  = PA_W'(row_b - ROW_W'(1)) * PA_W'(IMG_W) + PA_W'(col_b - COL_W'(1));
        pix_int   = int'(pix_addr);
        word_addr = ADDR_W'(pix_int / LANES);
        lane_cur  = LANE_W'(pix_int % LANES);
    end

    // Count taps currently travelling through the ROM latency pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_valid_q[i]);
        end
    end

    // Issue only when every outstanding tap is guaranteed a skid slot.
    assign issue = (state_q == ST_RUN)
                && ((int'(inflight) + int'(skid_count)) < DEPTH);

    // Last write leaves this cycle: nothing in flight and at most the popping entry.
    assign drain_empty = (inflight == '0)
                      && (skid_empty || ((skid_count == CNT_W'(1)) && fifo_we));

    // Next-state, scan counters and held ROM address.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        row_d      = row_q;
        col_d      = col_q;
        tap_d      = tap_q;
        rom_addr_d = (issue && !tap_pad) ? word_addr : rom_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = border_mode;
                    row_d   = (border_mode == BORDER_PAD) ? '0 : ROW_W'(1);
                    col_d   = (border_mode == BORDER_PAD) ? '0 : COL_W'(1);
                    tap_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        tap_d = '0;
                        if (col_q == col_last) begin
                            col_d = col_first;
                            if (row_q == row_last) begin
                                state_d = ST_DRAIN;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane index and pad flag travel alongside the ROM read.
    always_comb begin
        pipe_valid_d[0] = issue;
        pipe_lane_d[0]  = lane_cur;
        pipe_pad_d[0]   = tap_pad;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_lane_d[i]  = pipe_lane_q[i-1];
            pipe_pad_d[i]   = pipe_pad_q[i-1];
        end
    end

    // Control and pipeline registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= BORDER_SKIP;
            row_q      <= '0;
            col_q      <= '0;
            tap_q      <= '0;
            rom_addr_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_lane_q[i]  <= '0;
                pipe_pad_q[i]   <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tap_q      <= tap_d;
            rom_addr_q <= rom_addr_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_lane_q[i]  <= pipe_lane_d[i];
                pipe_pad_q[i]   <= pipe_pad_d[i];
            end
        end
    end

    // Padded taps emerge as zero without touching the ROM data.
    assign push_valid = pipe_valid_q[ROM_LAT-1];
    assign push_pix   = pipe_pad_q[ROM_LAT-1] ? '0 : lane_pix[pipe_lane_q[ROM_LAT-1]];

    tap_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_pix),
        .pop       (fifo_we),
        .pop_data  (skid_head),
        .count     (skid_count),
        .empty     (skid_empty)
    );

    assign fifo_we   = !skid_empty && !fifo_full;
    assign fifo_data = OUT_W'(skid_head);
    assign rom_addr  = rom_addr_d;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: doc/npu_window_streamer.md
# npu_window_streamer

Parametrised neighbourhood streamer for the NPU front end. It walks an image stored in a packed-pixel ROM and, for every centre pixel, emits its 3×3 neighbourhood (9 taps) into the NPU input FIFO. It generalises the fixed 640×480, 8-bit input path in four ways:

- image size, pixel and word widths, and ROM latency are parameters;
- a border mode is selectable;
- FIFO back-pressure is lossless;
- a frame start/done handshake is provided.

## Interface
Parameters:
- IMG_W, 640: image width in pixels (≥3)
- IMG_H, 480: image height in pixels (≥3)
- PIX_W, 8: pixel width in bits
- WORD_W, 64: ROM word width; a multiple of PIX_W, and WORD_W/PIX_W is a power of two
- OUT_W, 32: FIFO data width (≥PIX_W)
- ROM_LAT, 1: ROM read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle frame start request
- border_mode  in  1  0 = skip border centres, 1 = zero-pad; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last tap is written
- rom_addr  out  clog2(IMG_W*IMG_H*PIX_W/WORD_W)  ROM word address
- rom_data  in  WORD_W  ROM read data, valid ROM_LAT cycles after rom_addr
- fifo_full  in  1  downstream FIFO full
- fifo_data  out  OUT_W  tap pixel, zero-extended
- fifo_we  out  1  write strobe

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN: start is high.
  - RUN→DRAIN: the last tap has been issued.
  - DRAIN→DONE: the pipeline and skid buffer are empty.
  - DONE→IDLE: unconditional, next cycle. done is high only in DONE.
- start is ignored unless the state is IDLE.
- Centre scan order is row-major.
  - Skip mode: rows 1..IMG_H-2, columns 1..IMG_W-2.
  - Pad mode: all rows and columns.
- Tap order per centre (r,c) is column-major: (r-1,c-1), (r,c-1), (r+1,c-1), (r-1,c), (r,c), (r+1,c), (r-1,c+1), (r,c+1), (r+1,c+1).
- Taps per frame:
  - Skip mode: 9·(IMG_W-2)·(IMG_H-2).
  - Pad mode: 9·IMG_W·IMG_H.
- Addressing:
  - Pixel address p = row·IMG_W + col.
  - rom_addr = p / (WORD_W/PIX_W).
  - Lane = p mod (WORD_W/PIX_W); lane 0 is in the LSBs.
  - The lane index and a pad flag are delayed ROM_LAT cycles, alongside the read.
- Pad mode, out-of-bounds tap:
  - No ROM read is required and rom_addr holds its value.
  - The tap still occupies a pipeline slot and emerges as 0, so ordering is preserved.
- Arithmetic: row, column and tap counters are sized by clog2. Address arithmetic uses no signed wrap.
- Back-pressure:
  - A skid buffer of depth ROM_LAT+2 sits after the lane mux.
  - A tap is issued only when (in-flight + occupancy) < depth, so no returned data is ever dropped.
  - fifo_we = skid not empty & ~fifo_full.
  - fifo_we is never high while fifo_full is high.
- Reset at any time, including mid-frame:
  - State goes to IDLE.
  - Counters clear.
  - The pipeline and skid buffer flush.
- Reset values: busy 0, done 0, fifo_we 0, fifo_data 0, rom_addr 0.

## Timing
- Cycle 0: start high in IDLE.
- Cycle 1: RUN begins; rom_addr carries tap 0.
- Cycle 1+ROM_LAT: rom_data valid and captured into the skid buffer.
- Cycle 2+ROM_LAT: first fifo_we, provided fifo_full is low.
- Throughput: 1 tap per cycle while fifo_full is low. There are no bubbles at centre, row or word boundaries.
- fifo_full rising: at most depth taps are in flight or buffered. All of them are written after fifo_full falls, in order.
- done goes high the cycle after the final accepted write; busy falls in the same cycle.
- If start is high in the DONE cycle, it is ignored.

## Structure
- Shared package npu_stream_pkg holds:
  - the FSM state enum;
  - the border-mode constants;
  - the tap offset table (dr, dc for the 9 taps);
  - the clog2 helper.
- Sub-module tap_skid_fifo holds the parametrised depth/width skid buffer with occupancy output. Counters, addressing and the FSM stay in the top module.

## Test plan
Default configuration for all scenarios: IMG_W=8, IMG_H=6, WORD_W=64, ROM_LAT=1, ROM pixel value = p mod 256.

1. **Skip mode, no back-pressure.**
   - Exactly 216 writes, contiguous from cycle 3.
   - First 9 values: 0, 8, 16, 1, 9, 17, 2, 10, 18.
   - Last 9 values: 29, 37, 45, 30, 38, 46, 31, 39, 47.
   - One done pulse.
2. **Pad mode.**
   - Exactly 432 writes.
   - First centre (0,0) taps: 0, 0, 0, 0, 0, 8, 0, 1, 9.
   - Last centre (5,7) taps: 38, 46, 0, 39, 47, 0, 0, 0, 0.
3. **Random fifo_full, 50% duty, ROM_LAT=1 and ROM_LAT=3.**
   - The write sequence is identical to scenario 1.
   - No loss and no duplicates.
   - fifo_we is never high with fifo_full high.
4. **fifo_full held high for 20 cycles mid-row.**
   - No writes during the hold.
   - After release, the writes resume with the next expected value.
5. **Reset after 100 writes.**
   - fifo_we, busy and done are low from the next cycle.
   - A new start reproduces the full scenario 1 sequence from 0.
6. **Start pulses while busy and during DONE.**
   - Both are ignored.
   - Exactly one frame and one done pulse.
